i2s_rx_stereo: RTL and testbench

Parameterised I2S master-mode receiver for the mic front end. Generates BCLK/LRCLK from the system clock and captures both left and right channels. Supports I2S or left-justified framing. Words go into a small tagged FIFO with a valid/ready output toward the signal-processing chain; overflow is flagged, not silent.

---
 rtl/i2s_rx_stereo.sv | 118 +++++++++++
 tb/tb_i2s_rx_stereo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stereo.sv
// I2S / left-justified master-mode stereo receiver: generates BCLK/LRCLK from clk,
// deserialises both slots and queues tagged words in a show-ahead FIFO.
module i2s_rx_stereo #(
  parameter int CLK_DIV_HALF = 50,
  parameter int SLOT_BITS    = 32,
  parameter int DATA_BITS    = 24,
  parameter int SAMPLE_BITS  = 24,
  parameter int MODE         = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sd,
  output logic                   bclk,
  output logic                   lrclk,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_ch,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int DIV_W = $clog2(CLK_DIV_HALF);
  localparam int POS_W = $clog2(SLOT_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OFF   = (MODE == 0) ? 1 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_BITS - 1);
  localparam logic [31:0]      WIN_LO   = OFF;
  localparam logic [31:0]      WIN_HI   = DATA_BITS + OFF;
  localparam logic [31:0]      BIT_LAST = DATA_BITS - 1 + OFF;

  logic [DIV_W-1:0]     div;
  logic [POS_W-1:0]     pos;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [SAMPLE_BITS-1:0] word_fit;
  logic [31:0]          pos_ext;
  logic terminal, rise_evt, fall_evt, in_win, push_req;

  assign terminal  = enable && (div == DIV_LAST);
  assign rise_evt  = terminal && !bclk;
  assign fall_evt  = terminal && bclk;
  assign pos_ext   = 32'(pos);
  assign in_win    = (pos_ext >= WIN_LO) && (pos_ext < WIN_HI);
  assign shift_nxt = {shreg[DATA_BITS-2:0], sd};
  assign push_req  = rise_evt && in_win && (pos_ext == BIT_LAST);

  // Narrow outputs keep the MSBs; wide outputs left-align and zero-fill.
  if (SAMPLE_BITS >= DATA_BITS) begin : g_pad
    assign word_fit = SAMPLE_BITS'(shift_nxt) << (SAMPLE_BITS - DATA_BITS);
  end else begin : g_trunc
    assign word_fit = shift_nxt[DATA_BITS-1 -: SAMPLE_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      pos   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      shreg <= '0;
    end else if (!enable) begin
      div   <= '0;
      pos   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      shreg <= '0;
    end else begin
      div <= terminal ? '0 : div + 1'b1;
      if (terminal) bclk <= ~bclk;
      if (fall_evt) begin
        if (pos == POS_LAST) begin
          pos   <= '0;
          lrclk <= ~lrclk;
        end else begin
          pos <= pos + 1'b1;
        end
      end
      if (rise_evt && in_win) shreg <= shift_nxt;
    end
  end

  // Output FIFO: extra pointer bit distinguishes full from empty.
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [SAMPLE_BITS:0] mem [FIFO_DEPTH];
  logic empty, full, do_pop, do_push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = !empty && sample_ready;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {lrclk, word_fit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign sample_valid = !empty;
  assign {sample_ch, sample_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: a mic model follows the generated BCLK and several
// parameter variants receive the same streams.
module tb_i2s_rx_stereo;

  logic clk = 1'b0;
  logic rst, enable, ready, clr;
  logic sd_i2s, sd_lj;
  int   fcnt = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   run = 0;
  int   maxrun = 0;
  logic track = 1'b0;

  always #5 clk = ~clk;

  logic b0, l0, v0, c0, o0;  logic [23:0] d0;
  logic b1, l1, v1, c1, o1;  logic [23:0] d1;
  logic b4, l4, v4, c4, o4;  logic [23:0] d4;
  logic b2, l2, v2, c2, o2;  logic [15:0] d2;
  logic b3, l3, v3, c3, o3;  logic [31:0] d3;

  logic [32:0] q0[$], q1[$], q2[$], q3[$], q4[$];

  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .DATA_BITS(24), .SAMPLE_BITS(24), .MODE(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .sd(sd_i2s), .bclk(b0), .lrclk(l0), .sample_data(d0),
    .sample_ch(c0), .sample_valid(v0), .sample_ready(ready), .overflow(o0), .clear_overflow(clr));
  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .DATA_BITS(24), .SAMPLE_BITS(24), .MODE(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .sd(sd_lj), .bclk(b1), .lrclk(l1), .sample_data(d1),
    .sample_ch(c1), .sample_valid(v1), .sample_ready(ready), .overflow(o1), .clear_overflow(clr));
  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .DATA_BITS(24), .SAMPLE_BITS(24), .MODE(0), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .enable(enable), .sd(sd_lj), .bclk(b4), .lrclk(l4), .sample_data(d4),
    .sample_ch(c4), .sample_valid(v4), .sample_ready(ready), .overflow(o4), .clear_overflow(clr));
  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .DATA_BITS(24), .SAMPLE_BITS(16), .MODE(0), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .sd(sd_i2s), .bclk(b2), .lrclk(l2), .sample_data(d2),
    .sample_ch(c2), .sample_valid(v2), .sample_ready(ready), .overflow(o2), .clear_overflow(clr));
  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .DATA_BITS(24), .SAMPLE_BITS(32), .MODE(0), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .enable(enable), .sd(sd_i2s), .bclk(b3), .lrclk(l3), .sample_data(d3),
    .sample_ch(c3), .sample_valid(v3), .sample_ready(ready), .overflow(o3), .clear_overflow(clr));

  // Mic model: counts BCLK falls since start; left = A5C30F+frame, right = 123456+frame.
  always @(negedge b0 or negedge enable or posedge rst) begin
    if (rst || !enable) fcnt <= 0;
    else                fcnt <= fcnt + 1;
  end

  function automatic logic mic_bit(input int f, input int off);
    int p, bi, frame;
    logic [23:0] w;
    p     = f % 32;
    frame = f / 64;
    w     = (((f / 32) % 2) == 1) ? 24'h123456 + 24'(frame) : 24'hA5C30F + 24'(frame);
    bi    = p - off;
    if (bi >= 0 && bi < 24) return w[23 - bi];
    return 1'b0;
  endfunction

  assign sd_i2s = mic_bit(fcnt, 1);
  assign sd_lj  = mic_bit(fcnt, 0);

  always @(negedge clk) begin
    if (v0 && ready) q0.push_back({c0, 32'(d0)});
    if (v1 && ready) q1.push_back({c1, 32'(d1)});
    if (v2 && ready) q2.push_back({c2, 32'(d2)});
    if (v3 && ready) q3.push_back({c3, d3});
    if (v4 && ready) q4.push_back({c4, 32'(d4)});
    run <= v0 ? run + 1 : 0;
    if (!track)               maxrun <= 0;
    else if (v0 && run >= maxrun) maxrun <= run + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fcnt(input int n);
    for (int i = 0; i < 3000 && fcnt < n; i++) begin
      @(posedge clk); #1;
    end
    if (fcnt < n) check("wait_timeout", 64'(fcnt), 64'(n));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [32:0] exp4 [4];
  int base;

  initial begin
    exp4[0] = {1'b0, 32'hA5C30F};
    exp4[1] = {1'b1, 32'h123456};
    exp4[2] = {1'b0, 32'hA5C310};
    exp4[3] = {1'b1, 32'h123457};
    rst = 1'b1; enable = 1'b0; ready = 1'b1; clr = 1'b0;
    tick(3);
    check("rst_bclk", b0, 0);
    check("rst_lrclk", l0, 0);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_ch", c0, 0);
    check("rst_ovf", o0, 0);

    // I2S basics, left-justified, offset proof and width rules
    rst = 1'b0;
    tick(1);
    track = 1'b1;
    enable = 1'b1;
    wait_fcnt(70);
    check("i2s_L", q0[0], {1'b0, 32'hA5C30F});
    check("i2s_R", q0[1], {1'b1, 32'h123456});
    check("i2s_valid_width", 64'(maxrun), 1);
    check("lj_L", q1[0], {1'b0, 32'hA5C30F});
    check("lj_R", q1[1], {1'b1, 32'h123456});
    check("offset_L", q4[0], {1'b0, 32'h4B861E});
    check("trunc16_L", q2[0], {1'b0, 32'hA5C3});
    check("pad32_L", q3[0], {1'b0, 32'hA5C30F00});

    // Overflow with stalled consumer
    enable = 1'b0; ready = 1'b0; track = 1'b0;
    tick(4);
    base = q0.size();
    enable = 1'b1;
    wait_fcnt(130);
    check("ovf_after4", o0, 0);
    check("valid_after4", v0, 1);
    wait_fcnt(160);
    check("ovf_after5", o0, 1);
    enable = 1'b0;
    tick(1);
    ready = 1'b1;
    tick(10);
    check("drain_count", 64'(q0.size() - base), 4);
    for (int i = 0; i < 4; i++) check($sformatf("drain_word%0d", i), q0[base + i], exp4[i]);
    check("ovf_sticky", o0, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovf_cleared", o0, 0);

    // Pop coinciding with the 5th push on a full FIFO
    ready = 1'b0;
    tick(4);
    base = q0.size();
    enable = 1'b1;
    wait_fcnt(152);
    tick(1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    wait_fcnt(160);
    check("ovf_pushpop", o0, 0);
    enable = 1'b0;
    ready = 1'b1;
    tick(10);
    check("pushpop_count", 64'(q0.size() - base), 5);
    check("pushpop_first", q0[base], exp4[0]);
    check("pushpop_fifth", q0[base + 4], {1'b0, 32'hA5C311});

    // Async reset mid right slot
    ready = 1'b0;
    tick(4);
    enable = 1'b1;
    wait_fcnt(40);
    check("pre_rst_valid", v0, 1);
    check("pre_rst_lrclk", l0, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_bclk", b0, 0);
    check("arst_lrclk", l0, 0);
    check("arst_valid", v0, 0);
    check("arst_data", d0, 0);
    check("arst_ch", c0, 0);
    tick(1);
    rst = 1'b0;
    ready = 1'b1;
    base = q0.size();
    wait_fcnt(40);
    check("post_rst_first", q0[base], {1'b0, 32'hA5C30F});

    // Enable dropped mid right slot
    enable = 1'b0; ready = 1'b0;
    tick(4);
    base = q0.size();
    enable = 1'b1;
    wait_fcnt(40);
    enable = 1'b0;
    tick(4);
    check("dis_bclk", b0, 0);
    check("dis_lrclk", l0, 0);
    check("dis_valid", v0, 1);
    tick(300);
    ready = 1'b1;
    tick(5);
    check("dis_count", 64'(q0.size() - base), 1);
    check("dis_word", q0[base], {1'b0, 32'hA5C30F});
    check("dis_empty", v0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
